commit_regfile: RTL

Architectural register file plus register status (rename) table for the o3cpu back end, sitting directly downstream of the reorder buffer's commit port and beside dispatch. It absorbs the ROB's in-order commit stream (`ROB_we`/`addr_commit`/`data_commit`/`ROB_index_commit`) into 32 architectural registers. It records, per register, which in-flight ROB entry will produce its next value. Dispatch uses its read ports to get either a committed value or a ROB tag on which to wait.

---
 rtl/o3cpu_pkg.sv | 11 +
 rtl/commit_regfile_if.sv | 40 ++++
 rtl/reg_status_table.sv | 59 +++++
 rtl/commit_regfile.sv | 73 +++++++
 4 files changed

// File: rtl/o3cpu_pkg.sv
// Shared o3cpu back-end definitions: register address width and ROB tag type,
// used by the ROB, reservation stations and the commit register file.
package o3cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ROB_IDX_W  = 8;
  localparam logic [ROB_IDX_W-1:0] ROB_NO_TAG = '0;

  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/commit_regfile_if.sv
// Dispatch / lookup / commit / flush bundle between the back end and commit_regfile.
interface commit_regfile_if
  import o3cpu_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = ROB_IDX_W,
  parameter int XLEN            = 32
);
  logic                       disp_valid;
  reg_addr_t                  disp_rd;
  logic [ROB_ENTRY_WIDTH-1:0] disp_rob_idx;

  reg_addr_t                  rs1_addr;
  reg_addr_t                  rs2_addr;
  logic                       rs1_busy;
  logic                       rs2_busy;
  logic [ROB_ENTRY_WIDTH-1:0] rs1_tag;
  logic [ROB_ENTRY_WIDTH-1:0] rs2_tag;
  logic [XLEN-1:0]            rs1_data;
  logic [XLEN-1:0]            rs2_data;

  logic                       commit_we;
  reg_addr_t                  commit_addr;
  logic [XLEN-1:0]            commit_data;
  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_idx;

  logic                       flush;
  logic [5:0]                 busy_cnt;

  modport master (
    output disp_valid, disp_rd, disp_rob_idx, rs1_addr, rs2_addr,
           commit_we, commit_addr, commit_data, commit_rob_idx, flush,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data, busy_cnt
  );

  modport slave (
    input  disp_valid, disp_rd, disp_rob_idx, rs1_addr, rs2_addr,
           commit_we, commit_addr, commit_data, commit_rob_idx, flush,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_data, rs2_data, busy_cnt
  );
endinterface

// File: rtl/reg_status_table.sv
// Register status (rename) table: per-register busy bit and producer ROB tag,
// plus a running count of busy registers. Priority: rst > flush > dispatch > commit.
module reg_status_table
  import o3cpu_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = ROB_IDX_W
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      disp_valid,
  input  reg_addr_t                                 disp_rd,
  input  logic [ROB_ENTRY_WIDTH-1:0]                disp_rob_idx,
  input  logic                                      commit_we,
  input  reg_addr_t                                 commit_addr,
  input  logic [ROB_ENTRY_WIDTH-1:0]                commit_rob_idx,
  input  logic                                      flush,
  output logic [NUM_REGS-1:0]                       busy,
  output logic [NUM_REGS-1:0][ROB_ENTRY_WIDTH-1:0]  tag,
  output logic [5:0]                                busy_cnt
);
  logic [NUM_REGS-1:0]                      busy_q;
  logic [NUM_REGS-1:0][ROB_ENTRY_WIDTH-1:0] tag_q;
  logic [5:0]                               busy_cnt_q;

  logic disp_en;
  logic cm_hit;
  logic cnt_inc;
  logic cnt_dec;

  // A commit only releases the mapping if it is still the newest producer.
  assign disp_en = disp_valid && (disp_rd != '0);
  assign cm_hit  = commit_we && (commit_addr != '0) && busy_q[commit_addr] &&
                   (tag_q[commit_addr] == commit_rob_idx);
  assign cnt_inc = disp_en && !busy_q[disp_rd];
  assign cnt_dec = cm_hit && !(disp_en && (disp_rd == commit_addr));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q     <= '0;
      tag_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (cm_hit) begin
        busy_q[commit_addr] <= 1'b0;
        tag_q[commit_addr]  <= '0;
      end
      // Issued after the commit update so a same-register dispatch wins.
      if (disp_en) begin
        busy_q[disp_rd] <= 1'b1;
        tag_q[disp_rd]  <= disp_rob_idx;
      end
      busy_cnt_q <= busy_cnt_q + {5'b0, cnt_inc} - {5'b0, cnt_dec};
    end
  end

  assign busy     = busy_q;
  assign tag      = tag_q;
  assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/commit_regfile.sv
// Architectural register file with rename-status lookup for dispatch.
// Optional same-cycle commit bypass on lookups: COMMIT_REGFILE_BYPASS_EN.
module commit_regfile
  import o3cpu_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = ROB_IDX_W,
  parameter int XLEN            = 32
) (
  input  logic            clk,
  input  logic            rst,
  commit_regfile_if.slave rf_if
);
  logic [XLEN-1:0]                          rf [NUM_REGS];
  logic [NUM_REGS-1:0]                      busy;
  logic [NUM_REGS-1:0][ROB_ENTRY_WIDTH-1:0] tag;

  reg_status_table #(
    .ROB_ENTRY_WIDTH (ROB_ENTRY_WIDTH)
  ) u_status (
    .clk            (clk),
    .rst            (rst),
    .disp_valid     (rf_if.disp_valid),
    .disp_rd        (rf_if.disp_rd),
    .disp_rob_idx   (rf_if.disp_rob_idx),
    .commit_we      (rf_if.commit_we),
    .commit_addr    (rf_if.commit_addr),
    .commit_rob_idx (rf_if.commit_rob_idx),
    .flush          (rf_if.flush),
    .busy           (busy),
    .tag            (tag),
    .busy_cnt       (rf_if.busy_cnt)
  );

  // rf writes are independent of tag match and flush; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (rf_if.commit_we && (rf_if.commit_addr != '0)) begin
      rf[rf_if.commit_addr] <= rf_if.commit_data;
    end
  end

  function automatic logic bypass_hit(input reg_addr_t a);
`ifdef COMMIT_REGFILE_BYPASS_EN
    return rf_if.commit_we && (rf_if.commit_addr == a) && (a != '0) &&
           busy[a] && (tag[a] == rf_if.commit_rob_idx);
`else
    return (a != a);
`endif
  endfunction

  always_comb begin
    rf_if.rs1_busy = busy[rf_if.rs1_addr];
    rf_if.rs1_tag  = busy[rf_if.rs1_addr] ? tag[rf_if.rs1_addr] : '0;
    rf_if.rs1_data = busy[rf_if.rs1_addr] ? '0 : rf[rf_if.rs1_addr];
    if (bypass_hit(rf_if.rs1_addr)) begin
      rf_if.rs1_busy = 1'b0;
      rf_if.rs1_tag  = '0;
      rf_if.rs1_data = rf_if.commit_data;
    end
  end

  always_comb begin
    rf_if.rs2_busy = busy[rf_if.rs2_addr];
    rf_if.rs2_tag  = busy[rf_if.rs2_addr] ? tag[rf_if.rs2_addr] : '0;
    rf_if.rs2_data = busy[rf_if.rs2_addr] ? '0 : rf[rf_if.rs2_addr];
    if (bypass_hit(rf_if.rs2_addr)) begin
      rf_if.rs2_busy = 1'b0;
      rf_if.rs2_tag  = '0;
      rf_if.rs2_data = rf_if.commit_data;
    end
  end
endmodule
